// File: rtl/cond_flag_unit.sv
// NZCV status register and condition-code evaluator with in-flight
// flag-writer tracking and same-cycle bypass of ALU flag results.
module cond_flag_unit #(
    parameter int         MAX_PEND    = 3,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       iss_valid,
    output logic       iss_ready,
    input  logic       alu_valid,
    input  logic       alu_set,
    input  logic       alu_N,
    input  logic       alu_Z,
    input  logic       alu_C,
    input  logic       alu_V,
    input  logic       req_valid,
    input  logic [3:0] req_cond,
    output logic       req_ready,
    output logic       resp_valid,
    output logic       resp_pass,
    output logic [3:0] resp_flags,
    output logic [3:0] flags
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] MAX_P = CW'(MAX_PEND);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] pending, pending_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;
    logic [CW-1:0] eff;
    logic [3:0]    cond_q, cond_n;
    logic [3:0]    fire_cond;
    logic [3:0]    alu_flags, eval_flags;
    logic          wr, dec, iss_fire, fire;

    function automatic logic cond_eval(input logic [3:0] c,
                                       input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return ~z;
            4'h2:    return cf;
            4'h3:    return ~cf;
            4'h4:    return n;
            4'h5:    return ~n;
            4'h6:    return v;
            4'h7:    return ~v;
            4'h8:    return cf & ~z;
            4'h9:    return ~cf | z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return ~z & (n == v);
            4'hD:    return z | (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign wr         = alu_valid & alu_set;
    assign alu_flags  = {alu_N, alu_Z, alu_C, alu_V};
    assign eval_flags = wr ? alu_flags : flags;
    assign iss_ready  = pending < MAX_P;
    assign iss_fire   = iss_valid & iss_ready;
    // An untracked write (nothing pending) must not underflow the count.
    assign dec        = wr & (pending != '0);
    // Writer retiring this cycle is already reflected in eval_flags.
    assign eff        = pending - CW'(dec);
    assign req_ready  = (state == IDLE) & ~flush;

    // Next in-flight count; same-cycle issue and retire cancel.
    always_comb begin
        pending_n = pending;
        if (flush)
            pending_n = '0;
        else if (iss_fire & ~dec)
            pending_n = pending + ONE;
        else if (dec & ~iss_fire)
            pending_n = pending - ONE;
    end

    // Request FSM: answer now, or park until all older writers retire.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        cond_n     = cond_q;
        fire       = 1'b0;
        fire_cond  = req_cond;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (eff == '0) begin
                            fire = 1'b1;
                        end else begin
                            cond_n     = req_cond;
                            wait_cnt_n = eff;
                            state_n    = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wr) begin
                        if (wait_cnt == ONE) begin
                            fire      = 1'b1;
                            fire_cond = cond_q;
                            state_n   = IDLE;
                        end else begin
                            wait_cnt_n = wait_cnt - ONE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Architectural flags and in-flight counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags   <= RESET_FLAGS;
            pending <= '0;
        end else begin
            if (wr)
                flags <= alu_flags;
            pending <= pending_n;
        end
    end

    // FSM state and the parked request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            cond_q   <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            cond_q   <= cond_n;
        end
    end

    // Response pulse; result fields hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_pass  <= 1'b0;
            resp_flags <= '0;
        end else begin
            resp_valid <= fire;
            if (fire) begin
                resp_pass  <= cond_eval(fire_cond, eval_flags);
                resp_flags <= eval_flags;
            end
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios plus random traffic
// checked every cycle against a counting reference model.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       rst, flush, iss_valid, iss_ready;
    logic       alu_valid, alu_set, alu_N, alu_Z, alu_C, alu_V;
    logic       req_valid, req_ready;
    logic [3:0] req_cond;
    logic       resp_valid, resp_pass;
    logic [3:0] resp_flags, flags;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit       m_live = 0;
    bit [3:0] m_flags;
    int       m_pend;
    bit       m_wait;
    int       m_left;
    bit [3:0] m_cond;
    bit       m_rv, m_rp;
    bit [3:0] m_rf;

    cond_flag_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_set(alu_set),
        .alu_N(alu_N), .alu_Z(alu_Z), .alu_C(alu_C), .alu_V(alu_V),
        .req_valid(req_valid), .req_cond(req_cond),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_pass(resp_pass), .resp_flags(resp_flags),
        .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // ARM-style: even codes test a base predicate, odd codes invert it.
    function automatic bit ref_cond(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cf;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cf && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic m_step();
        bit       wr, fire;
        bit [3:0] ev, fc;
        int       older;
        if (rst) begin
            m_live = 1; m_flags = 4'b0000; m_pend = 0; m_wait = 0;
            m_rv = 0; m_rp = 0; m_rf = 0;
            return;
        end
        wr   = alu_valid && alu_set;
        ev   = wr ? {alu_N, alu_Z, alu_C, alu_V} : m_flags;
        fire = 0;
        fc   = req_cond;
        if (flush) begin
            m_wait = 0;
        end else if (!m_wait && req_valid) begin
            older = (wr && m_pend > 0) ? m_pend - 1 : m_pend;
            if (older == 0) fire = 1;
            else begin m_wait = 1; m_left = older; m_cond = req_cond; end
        end else if (m_wait && wr) begin
            m_left--;
            if (m_left == 0) begin fire = 1; fc = m_cond; m_wait = 0; end
        end
        if (flush) m_pend = 0;
        else m_pend = m_pend + int'(iss_valid && m_pend < 3)
                             - int'(wr && m_pend > 0);
        if (wr) m_flags = ev;
        m_rv = fire;
        if (fire) begin m_rp = ref_cond(fc, ev); m_rf = ev; end
    endtask

    task automatic idle_in();
        rst = 0; flush = 0; iss_valid = 0; alu_valid = 0; alu_set = 0;
        {alu_N, alu_Z, alu_C, alu_V} = 4'b0000;
        req_valid = 0; req_cond = 4'h0;
    endtask

    task automatic set_wr(input bit [3:0] nzcv);
        alu_valid = 1; alu_set = 1;
        {alu_N, alu_Z, alu_C, alu_V} = nzcv;
    endtask

    task automatic set_req(input bit [3:0] c);
        req_valid = 1; req_cond = c;
    endtask

    task automatic cyc();
        #1;
        if (m_live && !rst) begin
            chk("iss_ready", iss_ready, 4'(m_pend < 3));
            chk("req_ready", req_ready, 4'(!m_wait && !flush));
        end
        m_step();
        @(posedge clk);
        #1;
        chk("flags", flags, m_flags);
        chk("resp_valid", resp_valid, 4'(m_rv));
        chk("resp_pass", resp_pass, 4'(m_rp));
        chk("resp_flags", resp_flags, m_rf);
        idle_in();
    endtask

    initial begin
        idle_in();
        @(posedge clk); #1;
        // 1 reset
        rst = 1; cyc();
        #1;
        chk("rst_flags", flags, 4'b0000);
        chk("rst_iss_ready", iss_ready, 4'd1);
        chk("rst_req_ready", req_ready, 4'd1);
        chk("rst_resp_valid", resp_valid, 4'd0);
        // 2 no hazard
        set_wr(4'b0110); cyc();
        set_req(4'h0); cyc();
        chk("eq_valid", resp_valid, 4'd1);
        chk("eq_pass", resp_pass, 4'd1);
        chk("eq_flags", resp_flags, 4'b0110);
        set_req(4'h1); cyc();
        chk("ne_pass", resp_pass, 4'd0);
        set_req(4'hE); cyc();
        chk("al_pass", resp_pass, 4'd1);
        set_req(4'hF); cyc();
        chk("nv_pass", resp_pass, 4'd0);
        // 3 bypass
        iss_valid = 1; cyc();
        cyc();
        set_req(4'hA); set_wr(4'b1000); cyc();
        chk("byp_valid", resp_valid, 4'd1);
        chk("byp_pass", resp_pass, 4'd0);
        chk("byp_rflags", resp_flags, 4'b1000);
        chk("byp_flags", flags, 4'b1000);
        // 4 wait for two older writers
        iss_valid = 1; cyc();
        iss_valid = 1; cyc();
        set_req(4'h8); cyc();
        #1; chk("wait_req_ready", req_ready, 4'd0);
        set_wr(4'b0000); cyc();
        chk("wait_early", resp_valid, 4'd0);
        set_wr(4'b0010); cyc();
        chk("wait_valid", resp_valid, 4'd1);
        chk("wait_pass", resp_pass, 4'd1);
        #1; chk("wait_ready_back", req_ready, 4'd1);
        // 5 saturation
        repeat (3) begin iss_valid = 1; cyc(); end
        #1; chk("sat_iss_ready", iss_ready, 4'd0);
        iss_valid = 1; cyc();
        set_wr(4'b0100); cyc();
        #1; chk("sat_ready_back", iss_ready, 4'd1);
        set_wr(4'b0100); cyc();
        set_wr(4'b0100); cyc();
        set_req(4'h0); cyc();
        chk("sat_immediate", resp_valid, 4'd1);
        // 6 flush while waiting
        iss_valid = 1; cyc();
        iss_valid = 1; cyc();
        set_req(4'h0); cyc();
        set_req(4'h0); cyc();
        set_req(4'h0); flush = 1; cyc();
        chk("fl_no_resp", resp_valid, 4'd0);
        set_req(4'h0); cyc();
        chk("fl_resp", resp_valid, 4'd1);
        chk("fl_pass", resp_pass, 4'd1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            iss_valid = $urandom_range(0, 1);
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_set   = ($urandom_range(0, 3) != 0);
            {alu_N, alu_Z, alu_C, alu_V} = 4'($urandom);
            req_valid = $urandom_range(0, 1);
            req_cond  = 4'($urandom);
            if (m_pend == 0 && iss_valid) alu_valid = 0;
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
